// File: rtl/vend_session_ctrl_pkg.sv
// Shared definitions for the vending purchase-session controller.
// Holds the session state codes, hopper coin-type codes, default
// parameter values and the change-denomination priority helper.
package vend_session_ctrl_pkg;

   localparam int DEF_TIMEOUT_CYCLES = 200;
   localparam int DEF_PAYOUT_GAP     = 2;
   localparam int DEF_CNT_W          = 2;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SELECT  = 3'd1,
      ST_COLLECT = 3'd2,
      ST_PAYOUT  = 3'd3,
      ST_DONE    = 3'd4,
      ST_ABORT   = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      COIN_NONE    = 2'd0,
      COIN_NICKEL  = 2'd1,
      COIN_DIME    = 2'd2,
      COIN_QUARTER = 2'd3
   } coin_t;

   // Largest denomination still owed goes out first.
   function automatic coin_t next_coin(input logic have_q,
                                       input logic have_d,
                                       input logic have_n);
      coin_t c;
      if (have_q) begin
         c = COIN_QUARTER;
      end else if (have_d) begin
         c = COIN_DIME;
      end else if (have_n) begin
         c = COIN_NICKEL;
      end else begin
         c = COIN_NONE;
      end
      return c;
   endfunction

endpackage

// File: rtl/vend_session_ctrl_payout.sv
// Serial change payout sequencer.
// Latches three change counts on load, then while enabled emits one
// single-cycle hopper pulse at a time (quarters, dimes, nickels) with
// PAYOUT_GAP idle cycles between pulses.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   load                             capture quarter/dime/nickel counts
//   en                               sequencer may emit pulses
//   quarter_cnt/dime_cnt/nickel_cnt  counts to pay out
//   hop_quarter/hop_dime/hop_nickel  registered 1-cycle eject pulses
//   pay_done                         nothing left to pay
module vend_session_ctrl_payout
   import vend_session_ctrl_pkg::*;
#(
   parameter int PAYOUT_GAP = DEF_PAYOUT_GAP,
   parameter int CNT_W      = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             en,
   input  logic [CNT_W-1:0] quarter_cnt,
   input  logic [CNT_W-1:0] dime_cnt,
   input  logic [CNT_W-1:0] nickel_cnt,
   output logic             hop_quarter,
   output logic             hop_dime,
   output logic             hop_nickel,
   output logic             pay_done
);

   localparam int               GAP_W    = $clog2(PAYOUT_GAP + 1);
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(PAYOUT_GAP);
   localparam logic [GAP_W-1:0] GAP_ZERO = {GAP_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [CNT_W-1:0] q_r, d_r, n_r, q_s, d_s, n_s;
   logic [GAP_W-1:0] gap_r, gap_s;
   logic             hq_s, hd_s, hn_s;
   coin_t            pick_s;

   assign pick_s   = next_coin(q_r != CNT_ZERO, d_r != CNT_ZERO, n_r != CNT_ZERO);
   // Done as soon as the last coin is committed; the trailing gap is not waited out.
   assign pay_done = (pick_s == COIN_NONE);

   // Next-state: load counts, count down the gap, or commit the next coin.
   always_comb begin
      q_s   = q_r;
      d_s   = d_r;
      n_s   = n_r;
      gap_s = gap_r;
      hq_s  = 1'b0;
      hd_s  = 1'b0;
      hn_s  = 1'b0;
      if (load) begin
         q_s   = quarter_cnt;
         d_s   = dime_cnt;
         n_s   = nickel_cnt;
         gap_s = GAP_ZERO;
      end else if (!en) begin
         gap_s = gap_r;
      end else if (gap_r != GAP_ZERO) begin
         gap_s = gap_r - GAP_W'(1);
      end else begin
         case (pick_s)
            COIN_QUARTER: begin q_s = q_r - CNT_ONE; hq_s = 1'b1; gap_s = GAP_LOAD; end
            COIN_DIME:    begin d_s = d_r - CNT_ONE; hd_s = 1'b1; gap_s = GAP_LOAD; end
            COIN_NICKEL:  begin n_s = n_r - CNT_ONE; hn_s = 1'b1; gap_s = GAP_LOAD; end
            COIN_NONE:    gap_s = GAP_ZERO;
            default:      gap_s = GAP_ZERO;
         endcase
      end
   end

   // Count, gap and pulse registers; reset discards any owed change.
   always_ff @(posedge clk) begin
      if (reset) begin
         q_r         <= CNT_ZERO;
         d_r         <= CNT_ZERO;
         n_r         <= CNT_ZERO;
         gap_r       <= GAP_ZERO;
         hop_quarter <= 1'b0;
         hop_dime    <= 1'b0;
         hop_nickel  <= 1'b0;
      end else begin
         q_r         <= q_s;
         d_r         <= d_s;
         n_r         <= n_s;
         gap_r       <= gap_s;
         hop_quarter <= hq_s;
         hop_dime    <= hd_s;
         hop_nickel  <= hn_s;
      end
   end

endmodule

// File: rtl/vend_session_ctrl.sv
// Purchase-session sequencer in front of the vending machine.
// Admits a user on a face-recognition grant, latches the item choice,
// enables the coin acceptor, supervises inactivity timeouts and turns the
// machine's change counts into serial hopper pulses. All outputs registered.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   face_valid, face_ok        recognition result strobe and verdict
//   sel_req, sel_item          select strobe and item choice
//   coin_in                    coin accepted strobe
//   vm_dispense, vm_*_out      machine dispense strobe and change counts
//   vm_reset, vm_choice        machine held-reset and latched choice
//   coin_en                    coin acceptor enable
//   hop_quarter/dime/nickel    hopper eject pulses
//   busy                       session in progress
//   session_done, timeout, auth_fail, refund_req   status pulses
module vend_session_ctrl
   import vend_session_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int PAYOUT_GAP     = DEF_PAYOUT_GAP,
   parameter int CNT_W          = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             face_valid,
   input  logic             face_ok,
   input  logic             sel_req,
   input  logic             sel_item,
   input  logic             coin_in,
   input  logic             vm_dispense,
   input  logic [CNT_W-1:0] vm_nickel_out,
   input  logic [CNT_W-1:0] vm_dime_out,
   input  logic [CNT_W-1:0] vm_quarter_out,
   output logic             vm_reset,
   output logic             vm_choice,
   output logic             coin_en,
   output logic             hop_nickel,
   output logic             hop_dime,
   output logic             hop_quarter,
   output logic             busy,
   output logic             session_done,
   output logic             timeout,
   output logic             auth_fail,
   output logic             refund_req
);

   localparam int               TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES);
   localparam logic [TMR_W-1:0] TMR_ZERO = {TMR_W{1'b0}};

   state_t           state_r, state_s;
   logic [TMR_W-1:0] timer_r, timer_s, timer_dec_s;
   logic             coin_seen_r, coin_seen_s;
   logic             choice_s, auth_fail_s, load_s, pay_en_s, pay_done_s;

   assign load_s   = (state_r == ST_COLLECT) && vm_dispense;
   assign pay_en_s = (state_r == ST_PAYOUT);

   vend_session_ctrl_payout #(
      .PAYOUT_GAP (PAYOUT_GAP),
      .CNT_W      (CNT_W)
   ) u_payout (
      .clk         (clk),
      .reset       (reset),
      .load        (load_s),
      .en          (pay_en_s),
      .quarter_cnt (vm_quarter_out),
      .dime_cnt    (vm_dime_out),
      .nickel_cnt  (vm_nickel_out),
      .hop_quarter (hop_quarter),
      .hop_dime    (hop_dime),
      .hop_nickel  (hop_nickel),
      .pay_done    (pay_done_s)
   );

   // Session FSM next state, inactivity timer and coin-seen flag.
   always_comb begin
      state_s     = state_r;
      timer_s     = timer_r;
      coin_seen_s = coin_seen_r;
      choice_s    = vm_choice;
      auth_fail_s = 1'b0;
      timer_dec_s = (timer_r == TMR_ZERO) ? TMR_ZERO : (timer_r - TMR_W'(1));
      case (state_r)
         ST_IDLE: begin
            // Timer and refund flag are primed here so SELECT entry starts fresh.
            timer_s     = TMR_LOAD;
            coin_seen_s = 1'b0;
            if (face_valid && face_ok) begin
               state_s = ST_SELECT;
            end else if (face_valid) begin
               auth_fail_s = 1'b1;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_SELECT: begin
            if (sel_req) begin
               choice_s = sel_item;
               timer_s  = timer_dec_s;
               state_s  = ST_COLLECT;
            end else if (timer_r == TMR_ZERO) begin
               state_s = ST_ABORT;
            end else begin
               timer_s = timer_dec_s;
            end
         end
         ST_COLLECT: begin
            if (coin_in) begin
               coin_seen_s = 1'b1;
            end else begin
               coin_seen_s = coin_seen_r;
            end
            // Dispense and a coin both outrank expiry in the same cycle.
            if (vm_dispense) begin
               state_s = ST_PAYOUT;
            end else if (coin_in) begin
               timer_s = TMR_LOAD;
            end else if (timer_r == TMR_ZERO) begin
               state_s = ST_ABORT;
            end else begin
               timer_s = timer_dec_s;
            end
         end
         ST_PAYOUT: begin
            if (pay_done_s) begin
               state_s = ST_DONE;
            end else begin
               state_s = ST_PAYOUT;
            end
         end
         ST_DONE:  state_s = ST_IDLE;
         ST_ABORT: state_s = ST_IDLE;
         default:  state_s = ST_IDLE;
      endcase
   end

   // State, timer and registered outputs derived from the upcoming state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= ST_IDLE;
         timer_r      <= TMR_ZERO;
         coin_seen_r  <= 1'b0;
         vm_reset     <= 1'b1;
         vm_choice    <= 1'b0;
         coin_en      <= 1'b0;
         busy         <= 1'b0;
         session_done <= 1'b0;
         timeout      <= 1'b0;
         auth_fail    <= 1'b0;
         refund_req   <= 1'b0;
      end else begin
         state_r      <= state_s;
         timer_r      <= timer_s;
         coin_seen_r  <= coin_seen_s;
         vm_reset     <= !((state_s == ST_COLLECT) || (state_s == ST_PAYOUT));
         vm_choice    <= choice_s;
         coin_en      <= (state_s == ST_COLLECT);
         busy         <= (state_s != ST_IDLE);
         session_done <= (state_s == ST_DONE);
         timeout      <= (state_s == ST_ABORT);
         auth_fail    <= auth_fail_s;
         refund_req   <= (state_s == ST_ABORT) && coin_seen_s;
      end
   end

endmodule

// File: tb/tb_vend_session_ctrl.sv
// Self-checking bench for vend_session_ctrl: randomized sessions checked
// against expected event times computed from the session rules.
module tb_vend_session_ctrl;

   localparam int T  = 200;
   localparam int G  = 2;
   localparam int CW = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          face_valid = 1'b0, face_ok = 1'b0;
   logic          sel_req = 1'b0, sel_item = 1'b0;
   logic          coin_in = 1'b0, vm_dispense = 1'b0;
   logic [CW-1:0] vm_nickel_out = '0, vm_dime_out = '0, vm_quarter_out = '0;
   logic          vm_reset, vm_choice, coin_en;
   logic          hop_nickel, hop_dime, hop_quarter;
   logic          busy, session_done, timeout, auth_fail, refund_req;

   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;
   logic exp_choice = 1'b0;

   vend_session_ctrl #(.TIMEOUT_CYCLES(T), .PAYOUT_GAP(G), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .face_valid(face_valid), .face_ok(face_ok),
      .sel_req(sel_req), .sel_item(sel_item), .coin_in(coin_in),
      .vm_dispense(vm_dispense), .vm_nickel_out(vm_nickel_out),
      .vm_dime_out(vm_dime_out), .vm_quarter_out(vm_quarter_out),
      .vm_reset(vm_reset), .vm_choice(vm_choice), .coin_en(coin_en),
      .hop_nickel(hop_nickel), .hop_dime(hop_dime), .hop_quarter(hop_quarter),
      .busy(busy), .session_done(session_done), .timeout(timeout),
      .auth_fail(auth_fail), .refund_req(refund_req)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish, want finish before time limit");
      $fatal(1);
   end

   task automatic do_step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic start_session(output int f_edge);
      face_ok = 1'b1; face_valid = 1'b1;
      do_step();
      face_valid = 1'b0; face_ok = 1'b0;
      f_edge = cyc;
      vectors++;
      if ({busy, vm_reset, coin_en} !== 3'b110) begin
         miscompares++;
         $display("FAIL start_select: got busy/vm_reset/coin_en=%b want 110", {busy, vm_reset, coin_en});
      end
   endtask

   task automatic choose_item(input logic item);
      sel_item = item; sel_req = 1'b1;
      do_step();
      sel_req = 1'b0; sel_item = 1'($urandom);
      exp_choice = item;
      vectors++;
      if ({vm_choice, coin_en, vm_reset} !== {item, 2'b10}) begin
         miscompares++;
         $display("FAIL choose: got choice/coin_en/vm_reset=%b want %b", {vm_choice, coin_en, vm_reset}, {item, 2'b10});
      end
   endtask

   // Coins with random idle gaps; stray face/select pulses must be ignored.
   task automatic feed_coins(input int n, output int last_reload);
      last_reload = cyc;
      for (int i = 0; i < n; i++) begin
         int gap = $urandom_range(0, 4);
         for (int k = 0; k < gap; k++) begin
            face_valid = 1'($urandom); face_ok = 1'($urandom);
            sel_req = 1'($urandom); sel_item = ~exp_choice;
            do_step();
            face_valid = 1'b0; sel_req = 1'b0;
         end
         coin_in = 1'b1;
         do_step();
         coin_in = 1'b0;
         last_reload = cyc;
         vectors++;
         if ({coin_en, timeout, vm_choice, busy} !== {2'b10, exp_choice, 1'b1}) begin
            miscompares++;
            $display("FAIL coin_collect: got coin_en/timeout/choice/busy=%b want %b", {coin_en, timeout, vm_choice, busy}, {2'b10, exp_choice, 1'b1});
         end
      end
   endtask

   // Dispense then check every cycle of the payout against the coin schedule.
   task automatic dispense_check(input int q, input int d, input int n);
      int   tot, done_off, j;
      logic [3:0] exp_v, got_v;
      vm_quarter_out = CW'(q); vm_dime_out = CW'(d); vm_nickel_out = CW'(n);
      vm_dispense = 1'b1;
      do_step();
      vm_dispense = 1'b0;
      vm_quarter_out = CW'($urandom); vm_dime_out = CW'($urandom); vm_nickel_out = CW'($urandom);
      vectors++;
      if ({coin_en, busy, timeout} !== 3'b010) begin
         miscompares++;
         $display("FAIL dispense_entry: got coin_en/busy/timeout=%b want 010", {coin_en, busy, timeout});
      end
      tot = q + d + n;
      done_off = (tot == 0) ? 1 : 2 + (tot - 1) * (G + 1);
      for (int o = 1; o <= done_off; o++) begin
         do_step();
         exp_v = 4'b0000;
         if (o == done_off) begin
            exp_v[0] = 1'b1;
         end else if ((o - 1) % (G + 1) == 0) begin
            j = (o - 1) / (G + 1);
            if (j < q) exp_v[3] = 1'b1;
            else if (j < q + d) exp_v[2] = 1'b1;
            else exp_v[1] = 1'b1;
         end
         got_v = {hop_quarter, hop_dime, hop_nickel, session_done};
         vectors++;
         if (got_v !== exp_v) begin
            miscompares++;
            $display("FAIL payout q%0d d%0d n%0d off %0d: got Q/D/N/done=%b want %b", q, d, n, o, got_v, exp_v);
         end
      end
      do_step();
      vectors++;
      if ({busy, vm_reset, hop_quarter, hop_dime, hop_nickel, session_done} !== 6'b010000) begin
         miscompares++;
         $display("FAIL after_done: got busy/vm_reset/hops/done=%b want 010000", {busy, vm_reset, hop_quarter, hop_dime, hop_nickel, session_done});
      end
   endtask

   // Idle until the expected abort edge, checking timeout only there.
   task automatic wait_abort(input int deadline, input logic exp_ref);
      while (cyc < deadline) begin
         do_step();
         vectors++;
         if (cyc == deadline) begin
            if ({timeout, refund_req, vm_reset, coin_en} !== {1'b1, exp_ref, 2'b10}) begin
               miscompares++;
               $display("FAIL abort: got timeout/refund/vm_reset/coin_en=%b want %b", {timeout, refund_req, vm_reset, coin_en}, {1'b1, exp_ref, 2'b10});
            end
         end else if ({timeout, refund_req} !== 2'b00) begin
            miscompares++;
            $display("FAIL early_abort at %0d: got timeout/refund=%b want 00 (deadline %0d)", cyc, {timeout, refund_req}, deadline);
         end
      end
      do_step();
      vectors++;
      if ({busy, timeout, refund_req} !== 3'b000) begin
         miscompares++;
         $display("FAIL post_abort: got busy/timeout/refund=%b want 000", {busy, timeout, refund_req});
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      do_step(); do_step();
      reset = 1'b0;
      exp_choice = 1'b0;
      vectors++;
      if (vm_reset !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_vm_reset: got %b want 1", vm_reset);
      end
      vectors++;
      if ({vm_choice, coin_en, hop_nickel, hop_dime, hop_quarter, busy, session_done, timeout, auth_fail, refund_req} !== 10'b0) begin
         miscompares++;
         $display("FAIL reset_outputs: got %b want 0000000000", {vm_choice, coin_en, hop_nickel, hop_dime, hop_quarter, busy, session_done, timeout, auth_fail, refund_req});
      end
   endtask

   task automatic test_auth_fail();
      face_ok = 1'b0; face_valid = 1'b1;
      do_step();
      face_valid = 1'b0;
      vectors++;
      if ({auth_fail, busy, coin_en} !== 3'b100) begin
         miscompares++;
         $display("FAIL auth_fail_pulse: got auth_fail/busy/coin_en=%b want 100", {auth_fail, busy, coin_en});
      end
      do_step();
      vectors++;
      if ({auth_fail, busy, coin_en} !== 3'b000) begin
         miscompares++;
         $display("FAIL auth_fail_end: got auth_fail/busy/coin_en=%b want 000", {auth_fail, busy, coin_en});
      end
   endtask

   task automatic test_ignored_idle();
      for (int i = 0; i < 2; i++) begin
         vm_dispense = 1'b1; coin_in = 1'b1; sel_req = 1'b1; sel_item = ~exp_choice;
         vm_quarter_out = 2'd3;
         do_step();
         vm_dispense = 1'b0; coin_in = 1'b0; sel_req = 1'b0; vm_quarter_out = 2'd0;
         vectors++;
         if ({busy, coin_en, vm_choice, hop_quarter, vm_reset} !== {2'b00, exp_choice, 2'b01}) begin
            miscompares++;
            $display("FAIL idle_ignore: got busy/coin_en/choice/hopq/vm_reset=%b want %b", {busy, coin_en, vm_choice, hop_quarter, vm_reset}, {2'b00, exp_choice, 2'b01});
         end
      end
   endtask

   task automatic test_basic();
      int f, lr;
      start_session(f);
      choose_item(1'b0);
      feed_coins(3, lr);
      dispense_check(0, 0, 1);
   endtask

   task automatic test_payout_order();
      int f, lr;
      start_session(f);
      choose_item(1'($urandom));
      feed_coins(1, lr);
      dispense_check(2, 1, 1);
   endtask

   task automatic test_random_sessions();
      for (int s = 0; s < 6; s++) begin
         int f, lr;
         start_session(f);
         repeat ($urandom_range(0, 3)) do_step();
         choose_item(1'($urandom));
         feed_coins($urandom_range(0, 3), lr);
         dispense_check($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      end
   endtask

   task automatic test_timeout();
      int f, lr;
      start_session(f);
      wait_abort(f + T + 1, 1'b0);
      start_session(f);
      repeat ($urandom_range(0, 20)) do_step();
      choose_item(1'($urandom));
      wait_abort(f + T + 1, 1'b0);
      start_session(f);
      choose_item(1'($urandom));
      feed_coins(1, lr);
      wait_abort(lr + T + 1, 1'b1);
   endtask

   task automatic test_simultaneous();
      int   f, deadline;
      logic seen = 1'b0;
      start_session(f);
      choose_item(1'b1);
      while (cyc < f + T) do_step();
      coin_in = 1'b1;
      do_step();
      coin_in = 1'b0;
      vectors++;
      if ({timeout, busy, coin_en} !== 3'b011) begin
         miscompares++;
         $display("FAIL coin_at_expiry: got timeout/busy/coin_en=%b want 011", {timeout, busy, coin_en});
      end
      deadline = cyc + T + 1;
      while (cyc < deadline - 1) begin
         do_step();
         seen = seen | timeout;
      end
      vectors++;
      if (seen !== 1'b0) begin
         miscompares++;
         $display("FAIL reload_window: got timeout seen=%b want 0", seen);
      end
      dispense_check(0, 0, 1);
   endtask

   task automatic test_reset_payout();
      int   f, lr;
      logic any_hop = 1'b0;
      start_session(f);
      choose_item(1'b1);
      feed_coins(1, lr);
      vm_quarter_out = 2'd3; vm_dispense = 1'b1;
      do_step();
      vm_dispense = 1'b0; vm_quarter_out = 2'd0;
      do_step();
      vectors++;
      if (hop_quarter !== 1'b1) begin
         miscompares++;
         $display("FAIL first_quarter: got %b want 1", hop_quarter);
      end
      do_step();
      reset = 1'b1;
      do_step();
      reset = 1'b0;
      exp_choice = 1'b0;
      vectors++;
      if ({busy, vm_reset, hop_quarter, session_done, vm_choice} !== 5'b01000) begin
         miscompares++;
         $display("FAIL reset_in_payout: got busy/vm_reset/hopq/done/choice=%b want 01000", {busy, vm_reset, hop_quarter, session_done, vm_choice});
      end
      repeat (12) begin
         do_step();
         any_hop = any_hop | hop_quarter | hop_dime | hop_nickel | busy;
      end
      vectors++;
      if (any_hop !== 1'b0) begin
         miscompares++;
         $display("FAIL post_reset_hops: got activity=%b want 0", any_hop);
      end
   endtask

   initial begin
      test_reset();
      test_auth_fail();
      test_ignored_idle();
      test_basic();
      test_payout_order();
      test_random_sessions();
      test_timeout();
      test_simultaneous();
      test_reset_payout();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
